// File: rtl/depar_hdr_segmenter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : depar_hdr_segmenter
// Description : Pops packets from the packet FIFO, gathers the first
//               C_NUM_HDR_SEGS beats into a header bundle, extracts the VLAN
//               ID and streams the remaining beats to the payload FIFO.
//               Optional statistics counters: DEPAR_HDR_SEGMENTER_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module depar_hdr_segmenter #(
    parameter int C_AXIS_DATA_WIDTH  = 256,
    parameter int C_AXIS_TUSER_WIDTH = 128,
    parameter int C_NUM_HDR_SEGS     = 4,
    parameter int C_VLANID_WIDTH     = 12,
    parameter int C_VLAN_LSB         = 116
) (
    input  logic                                         axis_clk,
    input  logic                                         reset,
    input  logic [C_AXIS_DATA_WIDTH-1:0]                 pkt_fifo_tdata,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]                pkt_fifo_tuser,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0]               pkt_fifo_tkeep,
    input  logic                                         pkt_fifo_tlast,
    input  logic                                         pkt_fifo_empty,
    output logic                                         pkt_fifo_rd_en,
    input  logic                                         hdr_ready,
    input  logic                                         vlan_ready,
    input  logic                                         seg_ready,
    output logic [C_NUM_HDR_SEGS*C_AXIS_DATA_WIDTH-1:0]  hdr_tdata,
    output logic [C_NUM_HDR_SEGS*C_AXIS_TUSER_WIDTH-1:0] hdr_tuser,
    output logic [C_NUM_HDR_SEGS*C_AXIS_DATA_WIDTH/8-1:0] hdr_tkeep,
    output logic [C_NUM_HDR_SEGS-1:0]                    hdr_tlast,
    output logic                                         hdr_valid,
    output logic [C_VLANID_WIDTH-1:0]                    vlan,
    output logic                                         vlan_valid,
    output logic [C_AXIS_DATA_WIDTH-1:0]                 seg_tdata,
    output logic [C_AXIS_TUSER_WIDTH-1:0]                seg_tuser,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]               seg_tkeep,
    output logic                                         seg_tlast,
    output logic                                         seg_valid
`ifdef DEPAR_HDR_SEGMENTER_STATS_EN
    ,
    output logic [31:0]                                  stat_pkt_cnt,
    output logic [31:0]                                  stat_short_cnt
`endif
);

    localparam int W     = C_AXIS_DATA_WIDTH;
    localparam int TU    = C_AXIS_TUSER_WIDTH;
    localparam int KW    = C_AXIS_DATA_WIDTH / 8;
    localparam int N     = C_NUM_HDR_SEGS;
    localparam int IDX_W = $clog2(C_NUM_HDR_SEGS);
    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(C_NUM_HDR_SEGS - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_EMIT    = 2'd2,
        S_PAYLOAD = 2'd3
    } state_t;

    state_t           r_state;
    logic [IDX_W-1:0] r_idx;
    logic             r_pkt_done;
    logic             w_pop;

    // Header/VLAN space is only checked at packet start; collection never stalls on it.
    always_comb begin
        w_pop = 1'b0;
        if (!reset && !pkt_fifo_empty) begin
            case (r_state)
                S_IDLE:    w_pop = hdr_ready && vlan_ready;
                S_COLLECT: w_pop = 1'b1;
                S_PAYLOAD: w_pop = seg_ready;
                default:   w_pop = 1'b0;
            endcase
        end
    end

    assign pkt_fifo_rd_en = w_pop;

    always_ff @(posedge axis_clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_pkt_done <= 1'b0;
            hdr_tdata  <= '0;
            hdr_tuser  <= '0;
            hdr_tkeep  <= '0;
            hdr_tlast  <= '0;
            hdr_valid  <= 1'b0;
            vlan       <= '0;
            vlan_valid <= 1'b0;
            seg_tdata  <= '0;
            seg_tuser  <= '0;
            seg_tkeep  <= '0;
            seg_tlast  <= 1'b0;
            seg_valid  <= 1'b0;
        end else begin
            hdr_valid  <= 1'b0;
            vlan_valid <= 1'b0;
            seg_valid  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        for (int k = 1; k < N; k++) begin
                            hdr_tdata[k*W +: W]   <= '0;
                            hdr_tuser[k*TU +: TU] <= '0;
                            hdr_tkeep[k*KW +: KW] <= '0;
                            hdr_tlast[k]          <= 1'b0;
                        end
                        hdr_tdata[W-1:0]   <= pkt_fifo_tdata;
                        hdr_tuser[TU-1:0]  <= pkt_fifo_tuser;
                        hdr_tkeep[KW-1:0]  <= pkt_fifo_tkeep;
                        hdr_tlast[0]       <= pkt_fifo_tlast;
                        vlan               <= pkt_fifo_tdata[C_VLAN_LSB +: C_VLANID_WIDTH];
                        r_pkt_done         <= pkt_fifo_tlast;
                        if (pkt_fifo_tlast) begin
                            r_state    <= S_EMIT;
                            hdr_valid  <= 1'b1;
                            vlan_valid <= 1'b1;
                        end else begin
                            r_state <= S_COLLECT;
                            r_idx   <= IDX_W'(1);
                        end
                    end
                end
                S_COLLECT: begin
                    if (w_pop) begin
                        hdr_tdata[r_idx*W +: W]   <= pkt_fifo_tdata;
                        hdr_tuser[r_idx*TU +: TU] <= pkt_fifo_tuser;
                        hdr_tkeep[r_idx*KW +: KW] <= pkt_fifo_tkeep;
                        hdr_tlast[r_idx]          <= pkt_fifo_tlast;
                        if (pkt_fifo_tlast || (r_idx == c_last_idx)) begin
                            r_state    <= S_EMIT;
                            r_pkt_done <= pkt_fifo_tlast;
                            hdr_valid  <= 1'b1;
                            vlan_valid <= 1'b1;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                S_EMIT: begin
                    r_state <= r_pkt_done ? S_IDLE : S_PAYLOAD;
                end
                S_PAYLOAD: begin
                    if (w_pop) begin
                        seg_tdata <= pkt_fifo_tdata;
                        seg_tuser <= pkt_fifo_tuser;
                        seg_tkeep <= pkt_fifo_tkeep;
                        seg_tlast <= pkt_fifo_tlast;
                        seg_valid <= 1'b1;
                        if (pkt_fifo_tlast) begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef DEPAR_HDR_SEGMENTER_STATS_EN
    // A packet that ended before filling the last slot leaves that slot's tlast clear.
    always_ff @(posedge axis_clk or posedge reset) begin
        if (reset) begin
            stat_pkt_cnt   <= '0;
            stat_short_cnt <= '0;
        end else if (r_state == S_EMIT) begin
            stat_pkt_cnt <= stat_pkt_cnt + 32'd1;
            if (r_pkt_done && !hdr_tlast[N-1]) begin
                stat_short_cnt <= stat_short_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_depar_hdr_segmenter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_depar_hdr_segmenter
// Description : Directed self-checking bench for depar_hdr_segmenter (N=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_depar_hdr_segmenter;

    localparam int W  = 256;
    localparam int TU = 128;
    localparam int KW = 32;
    localparam int N  = 4;

    logic              axis_clk = 1'b0;
    logic              reset    = 1'b1;
    logic [W-1:0]      pkt_fifo_tdata;
    logic [TU-1:0]     pkt_fifo_tuser;
    logic [KW-1:0]     pkt_fifo_tkeep;
    logic              pkt_fifo_tlast;
    logic              pkt_fifo_empty;
    logic              pkt_fifo_rd_en;
    logic              hdr_ready, vlan_ready, seg_ready;
    logic [N*W-1:0]    hdr_tdata;
    logic [N*TU-1:0]   hdr_tuser;
    logic [N*KW-1:0]   hdr_tkeep;
    logic [N-1:0]      hdr_tlast;
    logic              hdr_valid;
    logic [11:0]       vlan;
    logic              vlan_valid;
    logic [W-1:0]      seg_tdata;
    logic [TU-1:0]     seg_tuser;
    logic [KW-1:0]     seg_tkeep;
    logic              seg_tlast;
    logic              seg_valid;
`ifdef DEPAR_HDR_SEGMENTER_STATS_EN
    logic [31:0]       stat_pkt_cnt, stat_short_cnt;
`endif

    depar_hdr_segmenter #(
        .C_AXIS_DATA_WIDTH (W),
        .C_AXIS_TUSER_WIDTH(TU),
        .C_NUM_HDR_SEGS    (N),
        .C_VLANID_WIDTH    (12),
        .C_VLAN_LSB        (116)
    ) dut (
        .axis_clk      (axis_clk),
        .reset         (reset),
        .pkt_fifo_tdata(pkt_fifo_tdata),
        .pkt_fifo_tuser(pkt_fifo_tuser),
        .pkt_fifo_tkeep(pkt_fifo_tkeep),
        .pkt_fifo_tlast(pkt_fifo_tlast),
        .pkt_fifo_empty(pkt_fifo_empty),
        .pkt_fifo_rd_en(pkt_fifo_rd_en),
        .hdr_ready     (hdr_ready),
        .vlan_ready    (vlan_ready),
        .seg_ready     (seg_ready),
        .hdr_tdata     (hdr_tdata),
        .hdr_tuser     (hdr_tuser),
        .hdr_tkeep     (hdr_tkeep),
        .hdr_tlast     (hdr_tlast),
        .hdr_valid     (hdr_valid),
        .vlan          (vlan),
        .vlan_valid    (vlan_valid),
        .seg_tdata     (seg_tdata),
        .seg_tuser     (seg_tuser),
        .seg_tkeep     (seg_tkeep),
        .seg_tlast     (seg_tlast),
        .seg_valid     (seg_valid)
`ifdef DEPAR_HDR_SEGMENTER_STATS_EN
        ,
        .stat_pkt_cnt  (stat_pkt_cnt),
        .stat_short_cnt(stat_short_cnt)
`endif
    );

    always #5 axis_clk = ~axis_clk;

    typedef struct {
        logic [W-1:0]  d;
        logic [TU-1:0] u;
        logic [KW-1:0] k;
        logic          l;
    } beat_t;

    beat_t fifo_q[$];
    beat_t seg_q[$];

    int total = 0;
    int bad   = 0;

    int cyc, hdr_cnt, pop_cnt, rd_seen, strobe_err, seg_first_cyc, err_cnt;
    int hdr_cyc[8];
    int pop_at[16];
    logic [N-1:0] tl_cap[8];
    logic [N*W-1:0]  cap_d;
    logic [N*TU-1:0] cap_u;
    logic [N*KW-1:0] cap_k;
    logic [11:0]     cap_vlan;

`define CHECK(tag, obs, exp) \
    begin \
        total++; \
        assert ((obs) === (exp)) else begin \
            bad++; \
            $error("FAIL %s: observed=%0h expected=%0h", tag, (obs), (exp)); \
        end \
    end

    function automatic logic [W-1:0] mk_d(int p, int b, logic [11:0] v);
        logic [W-1:0] d;
        logic [7:0] pb, bb;
        pb = p[7:0];
        bb = b[7:0];
        d = {8{pb, bb, 16'hA5C3}};
        if (b == 0) d[127:116] = v;
        return d;
    endfunction

    function automatic logic [TU-1:0] mk_u(int p, int b);
        logic [7:0] pb, bb;
        pb = p[7:0];
        bb = b[7:0];
        return {4{pb, bb, 16'h5A3C}};
    endfunction

    task automatic push_pkt(int p, int len, logic [11:0] v, logic [KW-1:0] keep);
        beat_t bt;
        for (int b = 0; b < len; b++) begin
            bt.d = mk_d(p, b, v);
            bt.u = mk_u(p, b);
            bt.k = keep;
            bt.l = (b == len - 1);
            fifo_q.push_back(bt);
        end
    endtask

    task automatic drive();
        if (fifo_q.size() == 0) begin
            pkt_fifo_empty = 1'b1;
            pkt_fifo_tdata = '0;
            pkt_fifo_tuser = '0;
            pkt_fifo_tkeep = '0;
            pkt_fifo_tlast = 1'b0;
        end else begin
            pkt_fifo_empty = 1'b0;
            pkt_fifo_tdata = fifo_q[0].d;
            pkt_fifo_tuser = fifo_q[0].u;
            pkt_fifo_tkeep = fifo_q[0].k;
            pkt_fifo_tlast = fifo_q[0].l;
        end
    endtask

    task automatic clear_rec();
        hdr_cnt = 0; pop_cnt = 0; rd_seen = 0; strobe_err = 0;
        seg_first_cyc = -1;
        seg_q.delete();
    endtask

    // One clock: pop decided from the pre-edge rd_en, outputs recorded 1ns after the edge.
    task automatic tick();
        logic  popped;
        beat_t sb;
        @(negedge axis_clk);
        popped = pkt_fifo_rd_en;
        @(posedge axis_clk);
        cyc++;
        if (popped && fifo_q.size() > 0) begin
            void'(fifo_q.pop_front());
            if (pop_cnt < 16) pop_at[pop_cnt] = cyc - 1;
            pop_cnt++;
        end
        #1;
        drive();
        if (hdr_valid) begin
            if (hdr_cnt < 8) begin
                hdr_cyc[hdr_cnt] = cyc;
                tl_cap[hdr_cnt]  = hdr_tlast;
            end
            cap_d = hdr_tdata; cap_u = hdr_tuser; cap_k = hdr_tkeep; cap_vlan = vlan;
            hdr_cnt++;
        end
        if (vlan_valid !== hdr_valid) strobe_err++;
        if (seg_valid) begin
            if (seg_q.size() == 0) seg_first_cyc = cyc;
            sb.d = seg_tdata; sb.u = seg_tuser; sb.k = seg_tkeep; sb.l = seg_tlast;
            seg_q.push_back(sb);
        end
        if (pkt_fifo_rd_en) rd_seen++;
    endtask

    task automatic collect(int n);
        repeat (n) tick();
    endtask

    initial begin
        cyc = 0;
        hdr_ready = 1'b1; vlan_ready = 1'b1; seg_ready = 1'b1;
        drive();
        clear_rec();
        reset = 1'b1;
        repeat (2) @(posedge axis_clk);
        #1;
        `CHECK("rst_hdr_valid", hdr_valid, 1'b0)
        `CHECK("rst_vlan_valid", vlan_valid, 1'b0)
        `CHECK("rst_seg_valid", seg_valid, 1'b0)
        `CHECK("rst_hdr_tlast", hdr_tlast, 4'b0000)
        `CHECK("rst_vlan", vlan, 12'h000)
        reset = 1'b0;

        // 6-beat packet: 4 header beats, 2 payload beats
        clear_rec();
        push_pkt(1, 6, 12'h123, '1);
        drive();
        collect(14);
        `CHECK("t1_hdr_cnt", hdr_cnt, 1)
        `CHECK("t1_vlan", cap_vlan, 12'h123)
        `CHECK("t1_hdr_tlast", tl_cap[0], 4'b0000)
        `CHECK("t1_slot0", cap_d[0 +: W], mk_d(1, 0, 12'h123))
        `CHECK("t1_slot3", cap_d[3*W +: W], mk_d(1, 3, 12'h0))
        `CHECK("t1_user2", cap_u[2*TU +: TU], mk_u(1, 2))
        `CHECK("t1_hdr_latency", hdr_cyc[0] - pop_at[3], 1)
        `CHECK("t1_strobes", strobe_err, 0)
        `CHECK("t1_seg_cnt", seg_q.size(), 2)
        if (seg_q.size() == 2) begin
            `CHECK("t1_seg0", seg_q[0].d, mk_d(1, 4, 12'h0))
            `CHECK("t1_seg0_last", seg_q[0].l, 1'b0)
            `CHECK("t1_seg1_last", seg_q[1].l, 1'b1)
            `CHECK("t1_seg_latency", seg_first_cyc - pop_at[4], 1)
        end
        `CHECK("t1_pops", pop_cnt, 6)

        // 1-beat packet: empty slots must be cleared
        clear_rec();
        push_pkt(2, 1, 12'h0AB, 32'h0000FFFF);
        drive();
        collect(6);
        `CHECK("t2_hdr_cnt", hdr_cnt, 1)
        `CHECK("t2_keep0", cap_k[0 +: KW], 32'h0000FFFF)
        `CHECK("t2_hdr_tlast", tl_cap[0], 4'b0001)
        `CHECK("t2_vlan", cap_vlan, 12'h0AB)
        for (int s = 1; s < N; s++) begin
            `CHECK("t2_slot_data_zero", cap_d[s*W +: W], {W{1'b0}})
            `CHECK("t2_slot_user_zero", cap_u[s*TU +: TU], {TU{1'b0}})
            `CHECK("t2_slot_keep_zero", cap_k[s*KW +: KW], {KW{1'b0}})
        end
        `CHECK("t2_seg_cnt", seg_q.size(), 0)

        // back-to-back exact-N packets
        clear_rec();
        push_pkt(3, 4, 12'h333, '1);
        push_pkt(4, 4, 12'h444, '1);
        drive();
        collect(14);
        `CHECK("t3_hdr_cnt", hdr_cnt, 2)
        `CHECK("t3_gap", hdr_cyc[1] - hdr_cyc[0], 5)
        `CHECK("t3_tlast0", tl_cap[0], 4'b1000)
        `CHECK("t3_tlast1", tl_cap[1], 4'b1000)
        `CHECK("t3_vlan1", cap_vlan, 12'h444)
        `CHECK("t3_seg_cnt", seg_q.size(), 0)
        `CHECK("t3_pops", pop_cnt, 8)

        // 9-beat packet with payload stalled by seg_ready
        clear_rec();
        seg_ready = 1'b0;
        push_pkt(5, 9, 12'h555, '1);
        drive();
        collect(6);
        rd_seen = 0;
        collect(10);
        `CHECK("t4_stall_rd_en", rd_seen, 0)
        `CHECK("t4_stall_seg", seg_q.size(), 0)
        `CHECK("t4_stall_pops", pop_cnt, 4)
        seg_ready = 1'b1;
        collect(10);
        `CHECK("t4_hdr_cnt", hdr_cnt, 1)
        `CHECK("t4_seg_cnt", seg_q.size(), 5)
        err_cnt = 0;
        for (int i = 0; i < seg_q.size(); i++) begin
            if (seg_q[i].d !== mk_d(5, 4 + i, 12'h0)) err_cnt++;
            if (seg_q[i].l !== (i == 4)) err_cnt++;
        end
        `CHECK("t4_seg_order", err_cnt, 0)

        // hdr_ready low blocks the start of a packet
        clear_rec();
        hdr_ready = 1'b0;
        push_pkt(6, 1, 12'h666, '1);
        drive();
        #1;
        `CHECK("t5_rd_en_blocked", pkt_fifo_rd_en, 1'b0)
        collect(3);
        `CHECK("t5_no_pop", pop_cnt, 0)
        `CHECK("t5_no_hdr", hdr_cnt, 0)
        hdr_ready = 1'b1;
        #1;
        `CHECK("t5_rd_en_release", pkt_fifo_rd_en, 1'b1)
        collect(4);
        `CHECK("t5_pop", pop_cnt, 1)
        `CHECK("t5_hdr_cnt", hdr_cnt, 1)
        `CHECK("t5_vlan", cap_vlan, 12'h666)

`ifdef DEPAR_HDR_SEGMENTER_STATS_EN
        `CHECK("stat_pkt_before_rst", stat_pkt_cnt, 32'd6)
        `CHECK("stat_short_before_rst", stat_short_cnt, 32'd2)
`endif

        // reset in the middle of header collection
        clear_rec();
        push_pkt(7, 4, 12'h777, '1);
        drive();
        collect(2);
        reset = 1'b1;
        #1;
        `CHECK("t6_rst_slot0", hdr_tdata[0 +: W], {W{1'b0}})
        `CHECK("t6_rst_tlast", hdr_tlast, 4'b0000)
        `CHECK("t6_rst_vlan", vlan, 12'h000)
        `CHECK("t6_rst_hdr_valid", hdr_valid, 1'b0)
        `CHECK("t6_rst_rd_en", pkt_fifo_rd_en, 1'b0)
        fifo_q.delete();
        drive();
        collect(2);
        `CHECK("t6_no_hdr_in_rst", hdr_cnt, 0)
        reset = 1'b0;
        clear_rec();
        push_pkt(8, 4, 12'h456, '1);
        drive();
        collect(8);
        `CHECK("t6_hdr_cnt", hdr_cnt, 1)
        `CHECK("t6_vlan", cap_vlan, 12'h456)
        `CHECK("t6_tlast", tl_cap[0], 4'b1000)
        `CHECK("t6_slot3", cap_d[3*W +: W], mk_d(8, 3, 12'h0))
        `CHECK("t6_seg_cnt", seg_q.size(), 0)
`ifdef DEPAR_HDR_SEGMENTER_STATS_EN
        `CHECK("t6_stat_pkt", stat_pkt_cnt, 32'd1)
        `CHECK("t6_stat_short", stat_short_cnt, 32'd0)
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/depar_hdr_segmenter.md
Name: depar_hdr_segmenter

Overview:
Parametrised successor to the fixed two-half packet splitter in the deparser front end. It pops packets from the packet fallthrough FIFO and gathers the first C_NUM_HDR_SEGS beats into one wide header bundle. It extracts the VLAN ID from beat 0 and streams any remaining beats to the payload segment FIFO. It also handles packets shorter than the header window, which the fixed splitter does not. It feeds header, VLAN and payload FIFOs consumed by the deparsing stage.

Parameters:
C_AXIS_DATA_WIDTH, 256, data width per beat (bits)
C_AXIS_TUSER_WIDTH, 128, tuser width per beat
C_NUM_HDR_SEGS, 4, beats collected into header bundle (2..8)
C_VLANID_WIDTH, 12, VLAN ID width
C_VLAN_LSB, 116, LSB position of VLAN ID within beat-0 tdata

Ports:
axis_clk  in  1  clock
reset  in  1  asynchronous, active-high reset
pkt_fifo_tdata  in  C_AXIS_DATA_WIDTH  head beat data (fallthrough)
pkt_fifo_tuser  in  C_AXIS_TUSER_WIDTH  head beat tuser
pkt_fifo_tkeep  in  C_AXIS_DATA_WIDTH/8  head beat tkeep
pkt_fifo_tlast  in  1  head beat is last of packet
pkt_fifo_empty  in  1  packet FIFO empty
pkt_fifo_rd_en  out  1  pop head beat (combinational)
hdr_ready  in  1  header FIFO not nearly full
vlan_ready  in  1  VLAN FIFO not nearly full
seg_ready  in  1  payload FIFO not nearly full
hdr_tdata  out  N*C_AXIS_DATA_WIDTH  header bundle data, slot k at [k*W +: W]
hdr_tuser  out  N*C_AXIS_TUSER_WIDTH  per-slot tuser
hdr_tkeep  out  N*C_AXIS_DATA_WIDTH/8  per-slot tkeep
hdr_tlast  out  N  per-slot tlast
hdr_valid  out  1  one-cycle write strobe to header FIFO
vlan  out  C_VLANID_WIDTH  VLAN ID of packet
vlan_valid  out  1  one-cycle write strobe to VLAN FIFO
seg_tdata / seg_tuser / seg_tkeep / seg_tlast  out  W / TU / W/8 / 1  payload beat
seg_valid  out  1  one-cycle write strobe to payload FIFO

Behaviour:
- Reset (asynchronous, any time): state to S_IDLE, slot index 0, all registered outputs and slot storage 0. A partially collected header is discarded. Beats already popped are lost, and no strobes issue until the next packet.
- S_IDLE: when !pkt_fifo_empty && hdr_ready && vlan_ready:
  - pop beat into slot 0; capture tdata[C_VLAN_LSB +: C_VLANID_WIDTH]; clear slots 1..N-1;
  - tlast=1 -> S_EMIT with pkt_done=1; else -> S_COLLECT, idx=1.
- S_COLLECT: when !pkt_fifo_empty, pop into slot idx.
  - If tlast=1 or idx==N-1 -> S_EMIT, with pkt_done=tlast.
  - Otherwise idx+1.
  - No ready gating here; space was reserved at S_IDLE.
- S_EMIT (exactly one cycle):
  - hdr_valid=1 and vlan_valid=1 simultaneously, with bundle and VLAN stable.
  - pkt_done -> S_IDLE; else -> S_PAYLOAD.
- S_PAYLOAD: when !pkt_fifo_empty && seg_ready, pop and register beat; seg_valid=1 next cycle. Exit to S_IDLE after popping tlast.
- pkt_fifo_rd_en = pop condition of current state, never asserted when pkt_fifo_empty=1.
- Latency: last header beat pop -> hdr_valid 1 cycle. Payload pop -> seg_valid 1 cycle.
- Sustained throughput is 1 beat/cycle, plus 1 bubble cycle (S_EMIT) per packet.
- Short packet (L < N beats): slots L..N-1 have tdata/tuser/tkeep/tlast = 0, hdr_tlast[L-1]=1, and no seg_valid is issued for that packet.
- Packet of exactly N beats: hdr_tlast[N-1]=1, no payload beats, return to S_IDLE.
- hdr_ready/vlan_ready are sampled only in S_IDLE. Deasserting them mid-packet does not stall collection (the nearly_full margin covers it).
- seg_ready low in S_PAYLOAD stalls popping; seg_valid stays 0 while stalled.
- Strobes hdr_valid, vlan_valid and seg_valid are 0 in every cycle other than those stated.

Optional Feature:
Macro DEPAR_HDR_SEGMENTER_STATS_EN.
- Defined: adds outputs stat_pkt_cnt (32b) and stat_short_cnt (32b).
  - stat_pkt_cnt increments in each S_EMIT cycle.
  - stat_short_cnt increments in S_EMIT when the packet had fewer than N beats.
  - Both wrap at 2^32 and clear on reset.
- Undefined: ports and counters absent; all other behaviour is identical.

Test Plan:
1. N=4, 6-beat packet, VLAN 0x123 at bits [127:116], all readies 1 -> 4 pops, then hdr_valid=1 for 1 cycle with vlan=0x123 and hdr_tlast=4'b0000, then 2 seg_valid beats with the second seg_tlast=1.
2. 1-beat packet, tkeep=32'h0000FFFF -> hdr_valid with slot0 keep 0x0000FFFF, hdr_tlast=4'b0001, slots 1..3 all zero, no seg_valid.
3. Back-to-back 4-beat packets with the FIFO never empty -> hdr_valid 5 cycles apart; hdr_tlast=4'b1000 each time; seg_valid never asserted.
4. seg_ready held 0 for 10 cycles during payload of a 9-beat packet -> pkt_fifo_rd_en=0 during those cycles, then 5 payload beats in order with no loss or duplication.
5. hdr_ready=0 with a packet waiting -> no pop; hdr_ready=1 -> collection starts the next cycle.
6. Assert reset after beat 2 of a 4-beat packet -> all outputs 0 immediately, no hdr_valid. The next packet is processed correctly; with STATS_EN, stat_pkt_cnt=1 after it and stat_short_cnt=0.
